// File: rtl/synth_pkg.sv
// Shared envelope types and constants for the synth audio path.
// Envelope values span 0..ENV_FULL and fit in ENV_W bits.
package synth_pkg;

  localparam int ENV_W    = 9;
  localparam int ENV_FULL = 256;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Envelope step prescaler: counts 0..DIV-1 while enabled.
// tick pulses on the enabled cycle the count wraps.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = ena && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (ena)
      cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/envelope_shaper.sv
// ADSR envelope applied to offset-binary audio, 1-cycle registered output.
// Define ENVELOPE_RETRIGGER_EN to let a gate in RELEASE restart ATTACK.
module envelope_shaper
  import synth_pkg::*;
#(
  parameter int W             = 12,
  parameter int TICK_DIV      = 4096,
  parameter int ATTACK_STEP   = 8,
  parameter int DECAY_STEP    = 4,
  parameter int SUSTAIN_LEVEL = 160,
  parameter int RELEASE_STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             gate,
  input  logic [W-1:0]     audio_in,
  output logic [W-1:0]     audio_out,
  output logic [ENV_W-1:0] env_level,
  output logic             busy
);

  typedef logic [ENV_W:0] ext_t;

  localparam ext_t FULL_X = ext_t'(ENV_FULL);
  localparam ext_t SUS_X  = ext_t'(SUSTAIN_LEVEL);
  localparam ext_t ATK_X  = ext_t'(ATTACK_STEP);
  localparam ext_t DEC_X  = ext_t'(DECAY_STEP);
  localparam ext_t REL_X  = ext_t'(RELEASE_STEP);
  localparam ext_t DFLR_X = ext_t'(SUSTAIN_LEVEL + DECAY_STEP);

  localparam logic [W-1:0]        MID   = W'(2 ** (W - 1));
  localparam logic signed [W+9:0] MID_X = (W+10)'(2 ** (W - 1));
  localparam logic signed [W+9:0] MAX_X = (W+10)'(2 ** W - 1);

  env_state_t     state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic [W-1:0]   aout_q, aout_d;
  logic           tick;
  logic           clr;
  ext_t           env_x, att_x, dec_x, rel_x;

  assign clr = ena && (state_q == IDLE) && gate;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .clr  (clr),
    .tick (tick)
  );

  assign env_x = {1'b0, env_q};
  assign att_x = (env_x + ATK_X > FULL_X) ? FULL_X : env_x + ATK_X;
  assign dec_x = (env_x >= DFLR_X) ? env_x - DEC_X : SUS_X;
  assign rel_x = (env_x >= REL_X) ? env_x - REL_X : '0;

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (gate)
            state_d = ATTACK;
        end
        ATTACK: begin
          if (!gate) begin
            state_d = RELEASE;
          end else if (tick) begin
            env_d = att_x[ENV_W-1:0];
            if (att_x == FULL_X)
              state_d = DECAY;
          end
        end
        DECAY: begin
          if (!gate) begin
            state_d = RELEASE;
          end else if (tick) begin
            env_d = dec_x[ENV_W-1:0];
            if (dec_x == SUS_X)
              state_d = SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (!gate)
            state_d = RELEASE;
        end
        RELEASE: begin
          if (tick) begin
            env_d = rel_x[ENV_W-1:0];
            if (rel_x == '0)
              state_d = IDLE;
          end
`ifdef ENVELOPE_RETRIGGER_EN
          // Retrigger resumes the climb from wherever release had got to
          if (gate) begin
            state_d = ATTACK;
            env_d   = env_q;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic signed [W:0]   c;
  logic signed [W+9:0] p, s, o;

  always_comb begin
    c = $signed({1'b0, audio_in}) - $signed({2'b01, {(W-1){1'b0}}});
    p = (W+10)'(c) * $signed({{(W+1){1'b0}}, env_q});
    s = p >>> 8;
    o = s + MID_X;
    if (o[W+9])
      aout_d = '0;
    else if (o > MAX_X)
      aout_d = '1;
    else
      aout_d = o[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      env_q   <= '0;
      aout_q  <= MID;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      aout_q  <= aout_d;
    end
  end

  assign audio_out = aout_q;
  assign env_level = env_q;
  assign busy      = (state_q != IDLE);

endmodule
